// File: rtl/mult8_pkg.sv
// Shared types and constants for the sequential 8x8 shift-add multiplier.
`timescale 1ns/1ps
package mult8_pkg;

  localparam int MULT8_W     = 8;
  localparam int MULT8_CNT_W = 3;
  localparam logic [MULT8_CNT_W-1:0] MULT8_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult8_state_e;

endpackage

// File: rtl/mult8_add_stage.sv
// Combinational 8-bit ripple-carry add (carry-in 0) returning sum and carry-out.
`timescale 1ns/1ps
module mult8_add_stage
  import mult8_pkg::*;
(
  input  logic [MULT8_W-1:0] x,
  input  logic [MULT8_W-1:0] y,
  output logic [MULT8_W-1:0] sum,
  output logic               cout
);

  logic [MULT8_W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < MULT8_W; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[MULT8_W];

endmodule

// File: rtl/mult8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with start/busy/done handshake.
// Optional abort input enabled by defining MULT8_ABORT_EN.
`timescale 1ns/1ps
module mult8_seq
  import mult8_pkg::*;
#(
  parameter int WIDTH = MULT8_W
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MULT8_ABORT_EN
  ,
  input  logic               abort
`endif
);

  mult8_state_e           state_q, state_d;
  logic [MULT8_CNT_W-1:0] count_q;
  logic [WIDTH-1:0]       mcand_q, hi_q, lo_q;
  logic [2*WIDTH-1:0]     product_q;
  logic                   load, finish;

  logic [WIDTH-1:0]       sum;
  logic                   cout;
  logic [WIDTH:0]         acc;
  logic [2*WIDTH-1:0]     shifted;

  mult8_add_stage u_add (
    .x    (hi_q),
    .y    (mcand_q),
    .sum  (sum),
    .cout (cout)
  );

  // Carry-out lands in hi[7] after the shift, so no partial-product bit is lost.
  assign acc     = lo_q[0] ? {cout, sum} : {1'b0, hi_q};
  assign shifted = {acc, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MULT8_ABORT_EN
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        if (count_q == MULT8_LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mcand_q <= a;
        hi_q    <= '0;
        lo_q    <= b;
        count_q <= '0;
      end else if (state_q == RUN) begin
        {hi_q, lo_q} <= shifted;
        count_q      <= count_q + 3'd1;
      end
      if (finish) begin
        product_q <= shifted;
      end
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult8_seq.sv
// Self-checking bench for mult8_seq: vector table, handshake corner cases, random ops.
`timescale 1ns/1ps
module tb_mult8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[8];

  mult8_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single multiply with a 1-cycle start; optional start pulse mid-RUN with other operands.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                        input bit mid_start, input string nm);
    @(negedge clk); a = ta; b = tb; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~ta; b = tb + 8'd1;
    for (int i = 0; i < 8; i++) begin
      chk({nm, " busy"}, 16'(busy), 16'd1);
      chk({nm, " done"}, 16'(done), 16'd0);
      if (mid_start && i == 3) start = 1'b1;
      if (mid_start && i == 4) start = 1'b0;
      @(negedge clk);
    end
    chk({nm, " done pulse"}, 16'(done), 16'd1);
    chk({nm, " busy off"}, 16'(busy), 16'd0);
    chk({nm, " product"}, product, exp);
    @(negedge clk);
    chk({nm, " done low"}, 16'(done), 16'd0);
    chk({nm, " idle"}, 16'(busy), 16'd0);
    chk({nm, " product held"}, product, exp);
  endtask

  // Two multiplies with start held high through the first DONE.
  task automatic run_b2b(input logic [7:0] a1, input logic [7:0] b1,
                         input logic [7:0] a2, input logic [7:0] b2, input string nm);
    logic [15:0] p1, p2;
    p1 = ref_mul(a1, b1);
    p2 = ref_mul(a2, b2);
    @(negedge clk); a = a1; b = b1; start = 1'b1;
    @(negedge clk); a = a2; b = b2;
    for (int i = 0; i < 8; i++) begin
      chk({nm, " op1 busy"}, 16'(busy), 16'd1);
      @(negedge clk);
    end
    chk({nm, " op1 done"}, 16'(done), 16'd1);
    chk({nm, " op1 product"}, product, p1);
    @(negedge clk); start = 1'b0; a = 8'h00; b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk({nm, " op2 busy"}, 16'(busy), 16'd1);
      chk({nm, " op2 done"}, 16'(done), 16'd0);
      chk({nm, " op1 product held"}, product, p1);
      @(negedge clk);
    end
    chk({nm, " op2 done"}, 16'(done), 16'd1);
    chk({nm, " op2 product"}, product, p2);
    @(negedge clk);
    chk({nm, " op2 done low"}, 16'(done), 16'd0);
  endtask

  initial begin
    tbl[0] = '{8'h0D, 8'h0B, 16'h008F};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'h01, 8'hFF, 16'h00FF};
    tbl[3] = '{8'hFF, 8'h01, 16'h00FF};
    tbl[4] = '{8'h80, 8'h02, 16'h0100};
    tbl[5] = '{8'h00, 8'hA5, 16'h0000};
    tbl[6] = '{8'hAA, 8'h55, 16'h3872};
    tbl[7] = '{8'h0F, 8'hF0, 16'h0E10};

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset product", product, 16'h0000);
    rst_n = 1'b1;

    // Idle with no start: outputs stay at reset values.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle busy", 16'(busy), 16'd0);
      chk("idle done", 16'(done), 16'd0);
      chk("idle product", product, 16'h0000);
    end

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, 1'b0, $sformatf("vec%0d", i));

    run_b2b(8'h00, 8'hA5, 8'hA5, 8'h00, "b2b zero");
    run_b2b(8'hC3, 8'h7E, 8'h19, 8'hE4, "b2b mixed");

    run_op(8'h5A, 8'h3C, 16'h1518, 1'b1, "mid start");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, ref_mul(ra, rb), 1'(i % 5 == 0), $sformatf("rand%0d", i));
    end

    // Asynchronous reset during RUN cycle 4: immediate clear, no done afterwards.
    @(negedge clk); a = 8'h37; b = 8'h5C; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset busy", 16'(busy), 16'd1);
    chk("pre-reset product nonzero", 16'(product != 16'h0000), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 16'(busy), 16'd0);
    chk("async reset done", 16'(done), 16'd0);
    chk("async reset product", product, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post-reset no done", 16'(done), 16'd0);
      chk("post-reset busy", 16'(busy), 16'd0);
      chk("post-reset product", product, 16'h0000);
    end

    run_op(8'hE7, 8'h9B, ref_mul(8'hE7, 8'h9B), 1'b0, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
